mpc_div_30s_9s_21_seq: RTL and testbench

MPC_DIV_30S_9S_21_SEQ -- requirements
Module: mpc_div_30s_9s_21_seq

---
 rtl/mpc_div_30s_9s_21_seq.sv | 211 +++++++++++++++++++++
 tb/tb_mpc_div_30s_9s_21_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mpc_div_30s_9s_21_seq.sv
// Sequential signed divider: restoring radix-2 core with C-style truncating signed results.
// Optional macro MPC_DIV_SAT_EN saturates q on overflow instead of wrapping.
module mpc_div_30s_9s_21_seq #(
   parameter int A_W = 30,
   parameter int B_W = 9,
   parameter int Q_W = 21
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           ce,
   input  logic           start,
   input  logic [A_W-1:0] a,
   input  logic [B_W-1:0] b,
   output logic           ready,
   output logic           done,
   output logic [Q_W-1:0] q,
   output logic [B_W-1:0] r,
   output logic           ovf
);

   localparam int CNT_W = $clog2(A_W + 1);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(A_W - 1);

   // Largest positive magnitude and largest negative magnitude of a Q_W-bit signed quotient.
   localparam logic [A_W-1:0] QMAX_MAG = {{(A_W-Q_W+1){1'b0}}, {(Q_W-1){1'b1}}};
   localparam logic [A_W-1:0] QMIN_MAG = {{(A_W-Q_W){1'b0}}, 1'b1, {(Q_W-1){1'b0}}};
   localparam logic [Q_W-1:0] QMAX_VAL = {1'b0, {(Q_W-1){1'b1}}};
   localparam logic [Q_W-1:0] QMIN_VAL = {1'b1, {(Q_W-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   function automatic logic [A_W-1:0] abs_a(input logic [A_W-1:0] v);
      abs_a = v[A_W-1] ? (~v + {{(A_W-1){1'b0}}, 1'b1}) : v;
   endfunction

   function automatic logic [B_W-1:0] abs_b(input logic [B_W-1:0] v);
      abs_b = v[B_W-1] ? (~v + {{(B_W-1){1'b0}}, 1'b1}) : v;
   endfunction

   function automatic logic [Q_W-1:0] neg_q(input logic [Q_W-1:0] v);
      neg_q = ~v + {{(Q_W-1){1'b0}}, 1'b1};
   endfunction

   function automatic logic [B_W-1:0] neg_b(input logic [B_W-1:0] v);
      neg_b = ~v + {{(B_W-1){1'b0}}, 1'b1};
   endfunction

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sign_a_q, sign_a_d;
   logic             sign_q_q, sign_q_d;
   logic             b_zero_q, b_zero_d;
   logic [A_W-1:0]   quo_q, quo_d;
   logic [B_W-1:0]   rem_q, rem_d;
   logic [B_W-1:0]   dvs_q, dvs_d;
   logic [Q_W-1:0]   q_q, q_d;
   logic [B_W-1:0]   r_q, r_d;
   logic             ovf_q, ovf_d;
   logic             done_q, done_d;

   logic [B_W:0]     rem_sh_s;
   logic [B_W-1:0]   rem_sub_s;
   logic             fits_s;
   logic             ovf_fix_s;
   logic [Q_W-1:0]   q_wrap_s;
   logic [Q_W-1:0]   q_fix_s;
   logic [B_W-1:0]   r_fix_s;

   assign ready = (state_q == IDLE);
   assign done  = done_q;
   assign q     = q_q;
   assign r     = r_q;
   assign ovf   = ovf_q;

   // One restoring step: shift in the next dividend bit, subtract the divisor when it fits.
   always_comb begin
      rem_sh_s  = {rem_q, quo_q[A_W-1]};
      rem_sub_s = rem_sh_s[B_W-1:0] - dvs_q;
      fits_s    = (rem_sh_s >= {1'b0, dvs_q});
   end

   // Signed result formation from the unsigned quotient/remainder magnitudes.
   always_comb begin
      ovf_fix_s = b_zero_q | (sign_q_q ? (quo_q > QMIN_MAG) : (quo_q > QMAX_MAG));
      if (b_zero_q) begin
         q_wrap_s = {Q_W{1'b0}};
         r_fix_s  = {B_W{1'b0}};
      end else begin
         q_wrap_s = sign_q_q ? neg_q(quo_q[Q_W-1:0]) : quo_q[Q_W-1:0];
         r_fix_s  = sign_a_q ? neg_b(rem_q) : rem_q;
      end
`ifdef MPC_DIV_SAT_EN
      // With a zero divisor the saturation direction follows the dividend.
      if (ovf_fix_s) begin
         if (b_zero_q ? sign_a_q : sign_q_q) begin
            q_fix_s = QMIN_VAL;
         end else begin
            q_fix_s = QMAX_VAL;
         end
      end else begin
         q_fix_s = q_wrap_s;
      end
`else
      q_fix_s = q_wrap_s;
`endif
   end

   // Next-state and datapath update; everything holds while ce is low.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sign_a_d = sign_a_q;
      sign_q_d = sign_q_q;
      b_zero_d = b_zero_q;
      quo_d    = quo_q;
      rem_d    = rem_q;
      dvs_d    = dvs_q;
      q_d      = q_q;
      r_d      = r_q;
      ovf_d    = ovf_q;
      done_d   = done_q;
      if (ce) begin
         case (state_q)
            IDLE: begin
               done_d = 1'b0;
               if (start) begin
                  state_d  = CALC;
                  cnt_d    = CNT_ZERO;
                  sign_a_d = a[A_W-1];
                  sign_q_d = a[A_W-1] ^ b[B_W-1];
                  b_zero_d = (b == {B_W{1'b0}});
                  quo_d    = abs_a(a);
                  dvs_d    = abs_b(b);
                  rem_d    = {B_W{1'b0}};
               end else begin
                  state_d = IDLE;
               end
            end
            CALC: begin
               if (fits_s) begin
                  rem_d = rem_sub_s;
                  quo_d = {quo_q[A_W-2:0], 1'b1};
               end else begin
                  rem_d = rem_sh_s[B_W-1:0];
                  quo_d = {quo_q[A_W-2:0], 1'b0};
               end
               cnt_d = cnt_q + CNT_ONE;
               if (cnt_q == CNT_LAST) begin
                  state_d = FIX;
               end else begin
                  state_d = CALC;
               end
            end
            FIX: begin
               q_d     = q_fix_s;
               r_d     = r_fix_s;
               ovf_d   = ovf_fix_s;
               done_d  = 1'b1;
               cnt_d   = CNT_ZERO;
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
               cnt_d   = CNT_ZERO;
               done_d  = 1'b0;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= CNT_ZERO;
         sign_a_q <= 1'b0;
         sign_q_q <= 1'b0;
         b_zero_q <= 1'b0;
         quo_q    <= {A_W{1'b0}};
         rem_q    <= {B_W{1'b0}};
         dvs_q    <= {B_W{1'b0}};
         q_q      <= {Q_W{1'b0}};
         r_q      <= {B_W{1'b0}};
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sign_a_q <= sign_a_d;
         sign_q_q <= sign_q_d;
         b_zero_q <= b_zero_d;
         quo_q    <= quo_d;
         rem_q    <= rem_d;
         dvs_q    <= dvs_d;
         q_q      <= q_d;
         r_q      <= r_d;
         ovf_q    <= ovf_d;
         done_q   <= done_d;
      end
   end

endmodule

// File: tb/tb_mpc_div_30s_9s_21_seq.sv
// Directed bench for mpc_div_30s_9s_21_seq: vector table plus ce-stall, done-hold and reset-abort sequences.
module tb_mpc_div_30s_9s_21_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        ce;
   logic        start;
   logic [29:0] a;
   logic [8:0]  b;
   logic        ready;
   logic        done;
   logic [20:0] q;
   logic [8:0]  r;
   logic        ovf;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef MPC_DIV_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef struct {
      int a;
      int b;
      int q_wrap;
      int q_sat;
      int r;
      int ovf;
   } vec_t;

   vec_t vecs[18];

   mpc_div_30s_9s_21_seq dut (
      .clk   (clk),
      .rst   (rst),
      .ce    (ce),
      .start (start),
      .a     (a),
      .b     (b),
      .ready (ready),
      .done  (done),
      .q     (q),
      .r     (r),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Wait for ready, issue one start, count enabled edges until done (bounded).
   task automatic do_op(input int ia, input int ib, output int lat);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      a     = ia[29:0];
      b     = ib[8:0];
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      while (!done && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   initial begin
      int lat;
      int seen;
      int exp_q;

      vecs[0]  = '{1000, 7, 142, 142, 6, 0};
      vecs[1]  = '{-1000, 7, -142, -142, -6, 0};
      vecs[2]  = '{1000, -7, -142, -142, 6, 0};
      vecs[3]  = '{-1000, -7, 142, 142, -6, 0};
      vecs[4]  = '{-536870912, -256, 0, 1048575, 0, 1};
      vecs[5]  = '{5, 0, 0, 1048575, 0, 1};
      vecs[6]  = '{-5, 0, 0, -1048576, 0, 1};
      vecs[7]  = '{-536870912, 1, 0, -1048576, 0, 1};
      vecs[8]  = '{1048575, 1, 1048575, 1048575, 0, 0};
      vecs[9]  = '{1048576, 1, -1048576, 1048575, 0, 1};
      vecs[10] = '{-1048576, 1, -1048576, -1048576, 0, 0};
      vecs[11] = '{536870911, 255, 8224, 1048575, 31, 1};
      vecs[12] = '{0, -3, 0, 0, 0, 0};
      vecs[13] = '{7, -256, 0, 0, 7, 0};
      vecs[14] = '{-7, 2, -3, -3, -1, 0};
      vecs[15] = '{100000000, 100, 1000000, 1000000, 0, 0};
      vecs[16] = '{300000000, -256, 925277, -1048576, 0, 1};
      vecs[17] = '{-1048577, 1, 1048575, -1048576, 0, 1};

      rst   = 1'b1;
      ce    = 1'b1;
      start = 1'b0;
      a     = 30'd0;
      b     = 9'd0;
      #12;
      check("reset_ready", int'(ready), 1);
      check("reset_done", int'(done), 0);
      check("reset_q", int'($signed(q)), 0);
      check("reset_r", int'($signed(r)), 0);
      check("reset_ovf", int'(ovf), 0);
      @(negedge clk);
      rst = 1'b0;

      // Table: consecutive calls also exercise start accepted in the done cycle.
      for (int i = 0; i < 18; i++) begin
         do_op(vecs[i].a, vecs[i].b, lat);
         exp_q = SAT ? vecs[i].q_sat : vecs[i].q_wrap;
         check($sformatf("v%0d_latency", i), lat, 31);
         check($sformatf("v%0d_q", i), int'($signed(q)), exp_q);
         check($sformatf("v%0d_r", i), int'($signed(r)), vecs[i].r);
         check($sformatf("v%0d_ovf", i), int'(ovf), vecs[i].ovf);
      end

      // ce low for 5 cycles mid-CALC, plus a start pulse while busy.
      @(negedge clk);
      while (!ready) @(negedge clk);
      a     = 30'd1000;
      b     = 9'd7;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1 lat++;
      end
      ce    = 1'b0;
      a     = 30'd1;
      b     = 9'd1;
      start = 1'b1;
      check("busy_ready", int'(ready), 0);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1 lat++;
      end
      ce = 1'b1;
      @(posedge clk);
      #1 lat++;
      start = 1'b0;
      while (!done && lat < 100) begin
         @(posedge clk);
         #1 lat++;
      end
      check("stall_latency", lat, 36);
      check("stall_q", int'($signed(q)), 142);
      check("stall_r", int'($signed(r)), 6);
      check("stall_ovf", int'(ovf), 0);

      // done must hold while ce is low and drop on the next enabled edge.
      ce = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      check("done_hold_ce_low", int'(done), 1);
      ce = 1'b1;
      @(posedge clk);
      #1;
      check("done_drop", int'(done), 0);
      check("q_held", int'($signed(q)), 142);

      // Reset at iteration 10 aborts the division.
      @(negedge clk);
      a     = 30'd12345;
      b     = 9'd3;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      #2;
      check("abort_done", int'(done), 0);
      check("abort_q", int'($signed(q)), 0);
      check("abort_r", int'($signed(r)), 0);
      check("abort_ovf", int'(ovf), 0);
      check("abort_ready", int'(ready), 1);
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done) seen++;
      end
      check("abort_no_done", seen, 0);
      do_op(1000, 7, lat);
      check("post_rst_latency", lat, 31);
      check("post_rst_q", int'($signed(q)), 142);
      check("post_rst_r", int'($signed(r)), 6);
      check("post_rst_ovf", int'(ovf), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
